// File: rtl/spi_master_if.sv
// Request/response and SPI pin bundle for spi_master.
// The master modport is the controller itself; slave is everything around it.
interface spi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready, miso,
        output req_ready, rsp_valid, rsp_rdata, sclk, cs_n, mosi
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready, miso,
        input  req_ready, rsp_valid, rsp_rdata, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 register-access master: one request becomes one cs_n frame
// (write: 02/addr/strb/data, read: 03/addr/32 capture bits), then one response.
module spi_master #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int         WR_BITS   = 8 + ADDR_WIDTH + 4 + DATA_WIDTH;
    localparam int         RD_BITS   = 8 + ADDR_WIDTH + DATA_WIDTH;
    localparam int         FRAME_W   = WR_BITS;
    localparam int         DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, RESP} state_t;

    state_t                state, state_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic [6:0]            bit_cnt;
    logic [FRAME_W-1:0]    tx_sreg;
    logic [FRAME_W-1:0]    frame_in;
    logic [DATA_WIDTH-1:0] rx_sreg;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  is_write;
    logic                  sclk_q;
    logic                  cs_n_q;

    logic div_tick, last_bit;
    logic accept, rise, fall, end_hold, end_gap;
    logic req_ready, rsp_valid;

    assign div_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == (is_write ? 7'(WR_BITS) : 7'(RD_BITS)));

    // Read frames are left-aligned; the zero tail is what MOSI shows while MISO is captured.
    always_comb begin
        if (bus.req_write)
            frame_in = {CMD_WRITE, bus.req_addr, bus.req_strb, bus.req_wdata};
        else
            frame_in = {CMD_READ, bus.req_addr, {(DATA_WIDTH + 4){1'b0}}};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)         state_nxt = SETUP;
            SETUP:   if (div_tick)       state_nxt = SHIFT;
            SHIFT:   if (fall && last_bit) state_nxt = HOLD;
            HOLD:    if (div_tick)       state_nxt = GAP;
            GAP:     if (div_tick)       state_nxt = RESP;
            RESP:    if (bus.rsp_ready)  state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // NOTE: every comb output gets a default before the case so no path infers a latch.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        end_hold  = 1'b0;
        end_gap   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = !rst;
                accept    = bus.req_valid && req_ready;
            end
            SETUP: rise = div_tick;
            SHIFT: begin
                rise = div_tick && !sclk_q;
                fall = div_tick && sclk_q;
            end
            HOLD:  end_hold  = div_tick;
            GAP:   end_gap   = div_tick;
            RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // SPI pins come straight from flops so cs_n and sclk never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sreg     <= '0;
            rx_sreg     <= '0;
            rsp_rdata_q <= '0;
            is_write    <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            if (state == IDLE || state == RESP || div_tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);

            if (accept) begin
                tx_sreg  <= frame_in;
                rx_sreg  <= '0;
                bit_cnt  <= '0;
                is_write <= bus.req_write;
                cs_n_q   <= 1'b0;
            end

            if (rise) begin
                sclk_q  <= 1'b1;
                rx_sreg <= {rx_sreg[DATA_WIDTH-2:0], bus.miso};
                bit_cnt <= bit_cnt + 7'd1;
            end

            if (fall) begin
                sclk_q  <= 1'b0;
                tx_sreg <= {tx_sreg[FRAME_W-2:0], 1'b0};
            end

            if (end_hold) begin
                cs_n_q  <= 1'b1;
                tx_sreg <= '0;
            end

            if (end_gap)
                rsp_rdata_q <= is_write ? '0 : rx_sreg;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.sclk      = sclk_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.mosi      = tx_sreg[FRAME_W-1];
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI register slave, table of transactions
// checked through a response scoreboard, plus back-pressure and abort sequences.
module tb_spi_master;
  localparam int CLK_DIV = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NV = 8;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0]  rdata;
    int           rises;
    int           cs_low;
    logic [127:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_master #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  vec_t vecs[NV];

  // ---------------- SPI slave model: 256-word register file at 0x000..0x3FC
  logic [31:0]  mem [256] = '{default: 32'h0};
  logic [127:0] s_shift = '0;
  logic [31:0]  s_rd = '0;
  int           s_bits = 0;
  int           sclk_bad = 0;
  int           cyc = 0;
  int           cs_fall_cyc = 0;
  int           cs_low = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_cs = 1'b1;

  always @(posedge clk) cyc++;

  always @(bus.sclk or bus.cs_n) begin
    if (prev_cs && !bus.cs_n) begin
      s_bits      = 0;
      s_shift     = '0;
      bus.miso    = 1'b0;
      cs_fall_cyc = cyc;
    end
    if (!prev_cs && bus.cs_n) begin
      cs_low   = cyc - cs_fall_cyc;
      bus.miso = 1'b0;
      if (s_bits == 76 && s_shift[75:68] == 8'h02 && s_shift[67:36] < 32'h400)
        for (int b = 0; b < 4; b++)
          if (s_shift[32+b])
            mem[s_shift[45:38]][8*b +: 8] = s_shift[8*b +: 8];
    end
    if (!prev_sclk && bus.sclk) begin
      if (bus.cs_n) sclk_bad++;
      else begin
        s_shift = {s_shift[126:0], bus.mosi};
        s_bits++;
        if (s_bits == 40)
          s_rd = (s_shift[39:32] == 8'h03 && s_shift[31:0] < 32'h400) ? mem[s_shift[9:2]] : 32'h0;
      end
    end
    if (prev_sclk && !bus.sclk && !bus.cs_n && s_bits >= 40 && s_bits < 72) begin
      bus.miso = s_rd[31];
      s_rd     = {s_rd[30:0], 1'b0};
    end
    prev_sclk = bus.sclk;
    prev_cs   = bus.cs_n;
  end

  // ---------------- helpers
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    check({tag, " req_ready before request"}, ok, 1'b1);
  endtask

  task automatic run_txn(input vec_t v, input bit hold_valid, input string tag);
    exp_t        e, got;
    int          n, bad;
    bit          ok;
    logic [31:0] first;
    n        = v.write ? 76 : 72;
    e.rdata  = v.exp_rdata;
    e.rises  = n;
    e.cs_low = CLK_DIV * (1 + 2 * n);
    e.frame  = v.write ? {52'h0, 8'h02, v.addr, v.strb, v.wdata}
                       : {56'h0, 8'h03, v.addr, 32'h0};
    wait_ready(tag);
    sb_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_strb  = v.strb;
    @(posedge clk); #1;
    if (!hold_valid) begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_strb  = 4'($urandom);
    end
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rsp_valid;
    end
    check({tag, " rsp_valid seen"}, ok, 1'b1);
    if (!ok) begin
      void'(sb_q.pop_front());
      bus.req_valid = 1'b0;
      return;
    end
    if (hold_valid) begin
      bad   = 0;
      first = bus.rsp_rdata;
      repeat (10) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.rsp_rdata !== first || bus.req_ready || !bus.cs_n) bad++;
      end
      check({tag, " stall cycles not stable"}, bad, 0);
      bus.req_valid = 1'b0;
    end
    got = sb_q.pop_front();
    check({tag, " rsp_rdata"}, bus.rsp_rdata, got.rdata);
    check({tag, " sclk rises"}, s_bits, got.rises);
    check({tag, " cs_n low cycles"}, cs_low, got.cs_low);
    check({tag, " mosi frame"}, s_shift, got.frame);
    check({tag, " sclk while cs_n high"}, sclk_bad, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " rsp_valid/req_ready after handshake"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  task automatic abort_seq();
    bit ok;
    int seen;
    wait_ready("abort");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_strb  = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = (s_bits >= 20);
    end
    check("abort reached address phase", ok, 1'b1);
    rst = 1'b1;
    #1;
    check("abort cs_n/sclk/mosi/rsp_valid", {bus.cs_n, bus.sclk, bus.mosi, bus.rsp_valid}, 4'b1000);
    repeat (3) @(negedge clk);
    check("abort req_ready in reset", bus.req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("abort req_ready after release", bus.req_ready, 1'b1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.cs_n) seen++;
    end
    check("abort no response or frame", seen, 0);
    check("abort rsp_rdata cleared", bus.rsp_rdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h010, 32'h11223344, 4'h1, 32'h0};
    vecs[3] = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBE44};
    vecs[4] = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0};
    vecs[5] = '{1'b1, 32'h020, 32'hA5A55A5A, 4'hC, 32'h0};
    vecs[6] = '{1'b0, 32'h020, 32'h0,        4'h0, 32'hA5A50000};
    vecs[7] = '{1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset cs_n", bus.cs_n, 1'b1);
    check("reset sclk/mosi", {bus.sclk, bus.mosi}, 2'b00);
    check("reset rsp_valid", bus.rsp_valid, 1'b0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset req_ready", bus.req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready after release", bus.req_ready, 1'b1);

    for (int i = 0; i < NV; i++)
      run_txn(vecs[i], 1'b0, $sformatf("v%0d", i));

    v = '{1'b0, 32'h3FC, 32'h0, 4'h0, 32'h12345678};
    run_txn(v, 1'b1, "backpressure");

    abort_seq();

    v = '{1'b1, 32'h040, 32'h0BADF00D, 4'hF, 32'h0};
    run_txn(v, 1'b0, "post-abort write");
    v = '{1'b0, 32'h040, 32'h0, 4'h0, 32'h0BADF00D};
    run_txn(v, 1'b0, "post-abort read");

    check("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
